// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants and types for the 7-segment scanner.
//   AN_OFF / DP_OFF : inactive levels of the active-low anode and decimal-point pins
//   scan_state_e    : per-slot scan state (blanking gap, then driving the digit)
package seg_scan_pkg;

   localparam logic AN_OFF = 1'b1;
   localparam logic DP_OFF = 1'b1;

   typedef enum logic {
      StBlank = 1'b0,
      StDrive = 1'b1
   } scan_state_e;

endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if: data/display bundle between the number producer, the scanner and the decoder.
//   load        : single-cycle strobe capturing value/dp_in
//   value       : packed hex digits, digit 0 rightmost
//   dp_in       : decimal-point request per digit
//   blank_lz    : leading-zero suppression enable (level)
//   hex_out     : nibble for the downstream hex-to-segment decoder
//   an          : anode enables, active-low
//   dp          : decimal point, active-low
//   frame_start : one-cycle pulse when digit 0's slot begins
interface seg_scan_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic                    load;
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic                    blank_lz;
   logic [3:0]              hex_out;
   logic [NUM_DIGITS-1:0]   an;
   logic                    dp;
   logic                    frame_start;

   modport master (
      output load, value, dp_in, blank_lz,
      input  hex_out, an, dp, frame_start
   );

   modport slave (
      input  load, value, dp_in, blank_lz,
      output hex_out, an, dp, frame_start
   );
endinterface

// File: rtl/seg_scan_tick.sv
// seg_scan_tick: modulo-REFRESH_DIV slot counter (the scan_tick of the scanner).
//   clk, rst : clock and synchronous active-high reset
//   cnt      : current count 0..REFRESH_DIV-1
//   wrap     : high while cnt is at its last value (count returns to 0 next cycle)
module seg_scan_tick #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned CNT_W       = $clog2(REFRESH_DIV)
) (
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap
);

   logic [CNT_W-1:0] cnt_q;

   always_comb begin
      cnt  = cnt_q;
      wrap = (cnt_q == CNT_W'(REFRESH_DIV - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (wrap) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed scanner for a common-anode multi-digit 7-segment display.
//   clk, rst : clock and synchronous active-high reset
//   bus      : seg_scan_if slave (load/value/dp_in/blank_lz in; hex_out/an/dp/frame_start out)
// Captured values sit in a pending register and are copied to the displayed shadow register
// only at frame boundaries, so a frame never mixes old and new digits. All outputs registered.
module seg_scan
   import seg_scan_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned BLANK_CYC   = 1000
) (
   input  logic        clk,
   input  logic        rst,
   seg_scan_if.slave   bus
);

   localparam int unsigned CW = $clog2(REFRESH_DIV);
   localparam int unsigned IW = $clog2(NUM_DIGITS);
   localparam int unsigned VW = 4 * NUM_DIGITS;
   // Every slot starts in this state; with no blanking gap the slot drives from cycle 0.
   localparam scan_state_e SLOT_START = (BLANK_CYC == 0) ? StDrive : StBlank;

   logic [CW-1:0] cnt;
   logic          wrap;

   seg_scan_tick #(
      .REFRESH_DIV (REFRESH_DIV),
      .CNT_W       (CW)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .cnt  (cnt),
      .wrap (wrap)
   );

   logic [IW-1:0]         idx_q, idx_d;
   scan_state_e           state_q, state_d;
   logic [VW-1:0]         pend_val_q, pend_val_d, shad_val_q, shad_val_d;
   logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, shad_dp_q, shad_dp_d;
   logic                  boundary, fs_pend_q;
   logic [NUM_DIGITS:1]   zero_above;
   logic [NUM_DIGITS-1:0] sup;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [3:0]            hex_q, hex_d;
   logic                  dp_q, dp_d, fs_q;

   // Next-state: digit index, slot FSM, double buffer.
   always_comb begin
      boundary   = wrap && (idx_q == IW'(NUM_DIGITS - 1));
      idx_d      = idx_q;
      state_d    = state_q;
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
      shad_val_d = shad_val_q;
      shad_dp_d  = shad_dp_q;

      if (wrap) begin
         idx_d = boundary ? '0 : idx_q + IW'(1);
      end

      if (wrap) begin
         state_d = SLOT_START;
      end else if ((BLANK_CYC != 0) && (cnt == CW'(BLANK_CYC - 1))) begin
         state_d = StDrive;
      end

      if (bus.load) begin
         pend_val_d = bus.value;
         pend_dp_d  = bus.dp_in;
      end
      // A load on the boundary cycle bypasses pending straight into shadow.
      if (boundary) begin
         shad_val_d = bus.load ? bus.value : pend_val_q;
         shad_dp_d  = bus.load ? bus.dp_in : pend_dp_q;
      end
   end

   // Leading-zero suppression and output decode.
   always_comb begin
      zero_above[NUM_DIGITS] = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_above[i] = zero_above[i+1] && (shad_val_q[4*i +: 4] == 4'h0);
      end
      sup[0] = 1'b0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         sup[i] = bus.blank_lz && zero_above[i];
      end

      an_d  = {NUM_DIGITS{AN_OFF}};
      hex_d = 4'h0;
      dp_d  = DP_OFF;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            hex_d = shad_val_q[4*i +: 4];
            dp_d  = shad_dp_q[i] ? ~DP_OFF : DP_OFF;
            if ((state_q == StDrive) && !sup[i]) begin
               an_d[i] = ~AN_OFF;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q      <= '0;
         state_q    <= SLOT_START;
         pend_val_q <= '0;
         pend_dp_q  <= '0;
         shad_val_q <= '0;
         shad_dp_q  <= '0;
         fs_pend_q  <= 1'b0;
         an_q       <= {NUM_DIGITS{AN_OFF}};
         hex_q      <= 4'h0;
         dp_q       <= DP_OFF;
         fs_q       <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         state_q    <= state_d;
         pend_val_q <= pend_val_d;
         pend_dp_q  <= pend_dp_d;
         shad_val_q <= shad_val_d;
         shad_dp_q  <= shad_dp_d;
         // Boundary -> idx/cnt reach 0 next cycle -> visible on outputs the cycle after.
         fs_pend_q  <= boundary;
         an_q       <= an_d;
         hex_q      <= hex_d;
         dp_q       <= dp_d;
         fs_q       <= fs_pend_q;
      end
   end

   assign bus.an          = an_q;
   assign bus.hex_out     = hex_q;
   assign bus.dp          = dp_q;
   assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed, table-driven bench for seg_scan (4 digits, 4-cycle slots, 1-cycle blank).
module tb_seg_scan;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   seg_scan_if #(.NUM_DIGITS(4)) bus ();

   seg_scan #(
      .NUM_DIGITS  (4),
      .REFRESH_DIV (4),
      .BLANK_CYC   (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] value;
      logic [3:0]  dp_in;
      logic        lz;
      logic [15:0] an_drive;  // an during DRIVE, one nibble per slot (slot 0 in [3:0])
      logic [15:0] hex;       // hex_out per slot
      logic [3:0]  dp_out;    // dp per slot
   } vec_t;

   vec_t vecs [7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic wait_fs();
      int k = 0;
      while (bus.frame_start !== 1'b1 && k < 40) begin
         step();
         k++;
      end
      chk("frame_start_arrives", {15'b0, bus.frame_start}, 16'h1);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      bus.load  = 1'b1;
      bus.value = v;
      bus.dp_in = d;
      step();
      bus.load  = 1'b0;
   endtask

   // Current sample must be the frame_start cycle. Checks 16 cycles; optional loads mid-frame.
   task automatic check_frame(input string tag, input logic [15:0] ean, input logic [15:0] ehex,
                              input logic [3:0] edp, input int l1_at, input logic [15:0] l1_val,
                              input int l2_at, input logic [15:0] l2_val);
      for (int j = 0; j < 16; j++) begin
         int s = j / 4;
         int c = j % 4;
         logic [3:0] exp_an;
         exp_an = (c == 0) ? 4'hF : ean[4*s +: 4];
         chk($sformatf("%s an j%0d", tag, j), {12'b0, bus.an}, {12'b0, exp_an});
         chk($sformatf("%s hex j%0d", tag, j), {12'b0, bus.hex_out}, {12'b0, ehex[4*s +: 4]});
         chk($sformatf("%s dp j%0d", tag, j), {15'b0, bus.dp}, {15'b0, edp[s]});
         chk($sformatf("%s fs j%0d", tag, j), {15'b0, bus.frame_start}, {15'b0, j == 0});
         bus.load = 1'b0;
         if (j == l1_at) begin
            bus.load = 1'b1; bus.value = l1_val; bus.dp_in = 4'b0;
         end
         if (j == l2_at) begin
            bus.load = 1'b1; bus.value = l2_val; bus.dp_in = 4'b0;
         end
         step();
      end
      bus.load = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst          = 1'b1;
      bus.load     = 1'b0;
      bus.value    = 16'h0;
      bus.dp_in    = 4'h0;
      bus.blank_lz = 1'b0;

      vecs[0] = '{16'h12AF, 4'b0100, 1'b0, 16'h7BDE, 16'h12AF, 4'b1011};
      vecs[1] = '{16'h0030, 4'b0000, 1'b1, 16'hFFDE, 16'h0030, 4'b1111};
      vecs[2] = '{16'h0000, 4'b0000, 1'b1, 16'hFFFE, 16'h0000, 4'b1111};
      vecs[3] = '{16'h0030, 4'b0000, 1'b0, 16'h7BDE, 16'h0030, 4'b1111};
      vecs[4] = '{16'h8001, 4'b1001, 1'b1, 16'h7BDE, 16'h8001, 4'b0110};
      vecs[5] = '{16'h0100, 4'b0001, 1'b1, 16'hFBDE, 16'h0100, 4'b1110};
      vecs[6] = '{16'h0000, 4'b1111, 1'b0, 16'h7BDE, 16'h0000, 4'b0000};

      // Reset held 3 cycles.
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst an", {12'b0, bus.an}, 16'hF);
         chk("rst dp", {15'b0, bus.dp}, 16'h1);
         chk("rst hex", {12'b0, bus.hex_out}, 16'h0);
         chk("rst fs", {15'b0, bus.frame_start}, 16'h0);
      end
      rst = 1'b0;
      step();
      chk("post_rst blank an", {12'b0, bus.an}, 16'hF);
      chk("post_rst no fs", {15'b0, bus.frame_start}, 16'h0);
      step();
      chk("first drive an", {12'b0, bus.an}, 16'hE);
      chk("first drive hex", {12'b0, bus.hex_out}, 16'h0);
      chk("first drive dp", {15'b0, bus.dp}, 16'h1);

      // Table: load mid-frame, then verify the whole following frame.
      for (int v = 0; v < 7; v++) begin
         bus.blank_lz = vecs[v].lz;
         wait_fs();
         do_load(vecs[v].value, vecs[v].dp_in);
         wait_fs();
         check_frame($sformatf("vec%0d", v), vecs[v].an_drive, vecs[v].hex, vecs[v].dp_out,
                     -1, 16'h0, -1, 16'h0);
      end

      // Mid-frame loads must not disturb the frame on display; last load wins.
      bus.blank_lz = 1'b0;
      wait_fs();
      do_load(16'h1234, 4'b0000);
      wait_fs();
      check_frame("old_frame", 16'h7BDE, 16'h1234, 4'hF, 3, 16'h9999, 7, 16'h5678);
      check_frame("new_frame", 16'h7BDE, 16'h5678, 4'hF, -1, 16'h0, -1, 16'h0);

      // Reset during digit 2's DRIVE.
      do_load(16'hABCD, 4'b0010);
      wait_fs();
      for (int i = 0; i < 9; i++) step();
      chk("d2 drive an", {12'b0, bus.an}, 16'hB);
      chk("d2 drive hex", {12'b0, bus.hex_out}, 16'hB);
      rst = 1'b1;
      step();
      chk("midrst an", {12'b0, bus.an}, 16'hF);
      chk("midrst hex", {12'b0, bus.hex_out}, 16'h0);
      chk("midrst dp", {15'b0, bus.dp}, 16'h1);
      chk("midrst fs", {15'b0, bus.frame_start}, 16'h0);
      rst = 1'b0;
      step();
      chk("midrst blank an", {12'b0, bus.an}, 16'hF);
      step();
      chk("midrst idx0 an", {12'b0, bus.an}, 16'hE);
      chk("midrst idx0 hex", {12'b0, bus.hex_out}, 16'h0);
      wait_fs();
      check_frame("cleared", 16'h7BDE, 16'h0000, 4'hF, -1, 16'h0, -1, 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
